// File: rtl/fp_special_encoder.sv
// Builds IEEE754 single-precision words from a class code plus sign/value, and
// presents them through a registered 2-entry skid buffer with a special-result counter.
module fp_special_encoder #(
  parameter bit PRESERVE_NAN = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_code,
  input  logic              in_sign,
  input  logic [31:0]       in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  spec_cnt
);

  localparam logic [2:0] CODE_ZERO   = 3'b000;
  localparam logic [2:0] CODE_PINF   = 3'b001;
  localparam logic [2:0] CODE_NINF   = 3'b010;
  localparam logic [2:0] CODE_NORMAL = 3'b011;
  localparam logic [2:0] CODE_NAN    = 3'b100;

  localparam logic [31:0] QNAN_WORD  = 32'h7FC0_0000;
  localparam logic [22:0] QNAN_MANT  = 23'h40_0000;

  // spec marks a word whose code was not "normal"; it travels with the data so the
  // counter reflects what was actually delivered, not what was accepted.
  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        spec;
  } word_t;

  word_t       enc_w;
  word_t       out_q;
  word_t       skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic [22:0] nan_mant;
  logic        accept;
  logic        xfer;
  logic        load;

  // Forcing the quiet bit also guarantees a non-zero mantissa, so a preserved
  // payload can never collapse into an infinity encoding.
  assign nan_mant = PRESERVE_NAN ? (in_value[22:0] | QNAN_MANT) : QNAN_MANT;

  // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    enc_w.data = QNAN_WORD;
    enc_w.err  = 1'b1;
    enc_w.spec = 1'b1;
    case (in_code)
      CODE_ZERO: begin
        enc_w.data = {in_sign, 31'b0};
        enc_w.err  = 1'b0;
      end
      CODE_PINF: begin
        enc_w.data = 32'h7F80_0000;
        enc_w.err  = 1'b0;
      end
      CODE_NINF: begin
        enc_w.data = 32'hFF80_0000;
        enc_w.err  = 1'b0;
      end
      CODE_NORMAL: begin
        enc_w.data = in_value;
        enc_w.err  = &in_value[30:23];
        enc_w.spec = 1'b0;
      end
      CODE_NAN: begin
        enc_w.data = {in_sign, 8'hFF, nan_mant};
        enc_w.err  = 1'b0;
      end
      default: ;
    endcase
  end

  // in_ready comes straight from a flop, so upstream never sees a combinational path
  // from out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign xfer     = out_valid_q & out_ready;
  assign load     = ~out_valid_q | out_ready;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: the data holders are reset too because out_data/out_err must read zero after reset.
      out_q        <= '0;
      skid_q       <= '0;
    end else if (load) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= enc_w;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= enc_w;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_cnt <= '0;
    end else if (xfer && out_q.spec && (spec_cnt != {CNT_W{1'b1}})) begin
      spec_cnt <= spec_cnt + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_fp_special_encoder.sv
// Scoreboard bench: two encoder instances (canonical NaN / 16-bit counter and
// payload-preserving NaN / 2-bit counter) driven in lockstep from one source.
module tb_fp_special_encoder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_code;
  logic        in_sign;
  logic [31:0] in_value;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [31:0] out_data_a;
  logic [15:0] cnt_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] out_data_b;
  logic [1:0]  cnt_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  fp_special_encoder #(.PRESERVE_NAN(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_code(in_code), .in_sign(in_sign), .in_value(in_value),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_err(out_err_a), .spec_cnt(cnt_a)
  );

  fp_special_encoder #(.PRESERVE_NAN(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_code(in_code), .in_sign(in_sign), .in_value(in_value),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_err(out_err_b), .spec_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the word was accepted.
  task automatic send(input logic [2:0] code, input logic sign, input logic [31:0] value,
                      input logic [31:0] exp_a, input logic [31:0] exp_b, input logic err);
    int n = 0;
    in_code  = code;
    in_sign  = sign;
    in_value = value;
    in_valid = 1'b1;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      in_valid = 1'b0;
    end else begin
      qa.push_back('{data: exp_a, err: err});
      qb.push_back('{data: exp_b, err: err});
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples one time unit before each rising edge, when a transfer is decided.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (out_valid_a && out_ready) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL a_unexpected: got %h, expected no word", out_data_a);
      end else begin
        e = qa.pop_front();
        check("a_data", out_data_a, e.data);
        check("a_err", {31'b0, out_err_a}, {31'b0, e.err});
      end
    end
    if (out_valid_b && out_ready) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL b_unexpected: got %h, expected no word", out_data_b);
      end else begin
        e = qb.pop_front();
        check("b_data", out_data_b, e.data);
        check("b_err", {31'b0, out_err_b}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'b000;
    in_sign   = 1'b0;
    in_value  = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_out_data", out_data_a, 32'h0);
    check("rst_out_err", {31'b0, out_err_a}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    check("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
    check("rst_cnt_b", {30'b0, cnt_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic classes, one per cycle, out_ready high
    out_ready = 1'b1;
    send(3'b000, 1'b1, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("latency_valid", {31'b0, out_valid_a}, 32'd1);
    send(3'b001, 1'b0, 32'h0, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
    send(3'b010, 1'b0, 32'h0, 32'hFF80_0000, 32'hFF80_0000, 1'b0);
    send(3'b011, 1'b0, 32'h7000_003E, 32'h7000_003E, 32'h7000_003E, 1'b0);
    drain();
    check("cnt_a_basic", {16'b0, cnt_a}, 32'd3);
    check("cnt_b_basic", {30'b0, cnt_b}, 32'd3);

    // NaN: a is canonical, b keeps payload with quiet bit forced
    send(3'b100, 1'b0, 32'h0000_003E, 32'h7FC0_0000, 32'h7FC0_003E, 1'b0);
    send(3'b100, 1'b1, 32'h0000_0000, 32'hFFC0_0000, 32'hFFC0_0000, 1'b0);
    drain();
    check("cnt_a_nan", {16'b0, cnt_a}, 32'd5);

    // Reserved code, then normal code with all-ones exponent
    send(3'b110, 1'b0, 32'h1234_5678, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1);
    drain();
    check("cnt_a_reserved", {16'b0, cnt_a}, 32'd6);
    send(3'b011, 1'b0, 32'h7F80_0001, 32'h7F80_0001, 32'h7F80_0001, 1'b1);
    drain();
    check("cnt_a_badnormal", {16'b0, cnt_a}, 32'd6);

    // Backpressure: A in output register, B in skid, C held off
    out_ready = 1'b0;
    send(3'b011, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    send(3'b011, 1'b1, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 1'b0);
    check("bp_in_ready_low", {31'b0, in_ready_a}, 32'd0);
    check("bp_b_in_ready_low", {31'b0, in_ready_b}, 32'd0);
    check("bp_held_a", out_data_a, 32'h3F80_0000);
    fork
      send(3'b011, 1'b0, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("bp_still_held", {31'b0, in_ready_a}, 32'd0);
        check("bp_stable_a", out_data_a, 32'h3F80_0000);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_nogap_1", {31'b0, out_valid_a}, 32'd1);
        @(negedge clk);
        check("bp_nogap_2", {31'b0, out_valid_a}, 32'd1);
      end
    join
    drain();
    check("bp_empty_after", {31'b0, out_valid_a}, 32'd0);

    // Async reset with the skid full
    out_ready = 1'b0;
    send(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    send(3'b001, 1'b0, 32'h0, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
    check("rst2_skid_full", {31'b0, in_ready_a}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst2_valid_async", {31'b0, out_valid_a}, 32'd0);
    check("rst2_b_valid_async", {31'b0, out_valid_b}, 32'd0);
    check("rst2_in_ready", {31'b0, in_ready_a}, 32'd1);
    check("rst2_cnt_a", {16'b0, cnt_a}, 32'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst2_no_stale", {31'b0, out_valid_a}, 32'd0);

    // Saturation of the 2-bit counter on instance b
    send(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    send(3'b000, 1'b1, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();
    check("sat_cnt_a_2", {16'b0, cnt_a}, 32'd2);
    check("sat_cnt_b_2", {30'b0, cnt_b}, 32'd2);
    send(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    send(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    send(3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drain();
    check("sat_cnt_a_5", {16'b0, cnt_a}, 32'd5);
    check("sat_cnt_b_3", {30'b0, cnt_b}, 32'd3);

    drain();
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
